// File: rtl/pcs_sync_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcs_sync_fsm
// Purpose  : PCS receive code-group synchronization controller. It detects
//            commas, acquires and tracks even/odd code-group alignment, and
//            reports sync OK/FAIL. Consumed code groups are forwarded one
//            clock later to the receive decoder.
// Ports    : clk, reset (sync, active-high)
//            signal_detect        - PMA signal present; low forces loss of sync
//            cg_strobe            - code_group_in / cg_exists valid this cycle
//            code_group_in[9:0]   - received group, bit 9 = 'a', bit 0 = 'j'
//            cg_exists            - code group is a valid code group
//            sync_status          - 1 = OK (SYNC_ACQUIRED_*), 0 = FAIL
//            rx_even              - parity of the last consumed group (1 = even)
//            code_group_out[9:0]  - registered copy of the last consumed group
//            code_group_out_valid - one-cycle pulse per consumed strobe
//            sync_state[3:0]      - current state encoding (debug)
// Revision : 1.0 - initial release
// ============================================================================
module pcs_sync_fsm #(
  parameter int COMMAS_TO_SYNC = 3,
  parameter int GOOD_CGS_MAX   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_detect,
  input  logic       cg_strobe,
  input  logic [9:0] code_group_in,
  input  logic       cg_exists,
  output logic       sync_status,
  output logic       rx_even,
  output logic [9:0] code_group_out,
  output logic       code_group_out_valid,
  output logic [3:0] sync_state
);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    ACQUIRE_SYNC_1   = 4'd2,
    COMMA_DETECT_2   = 4'd3,
    ACQUIRE_SYNC_2   = 4'd4,
    COMMA_DETECT_3   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_2A = 4'd8,
    SYNC_ACQUIRED_3  = 4'd9,
    SYNC_ACQUIRED_3A = 4'd10,
    SYNC_ACQUIRED_4  = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] good_cgs;

  logic comma;
  logic valid_comma;
  logic data;
  logic cgbad;
  logic cggood;
  logic good_max;
  logic next_is_cd;
  logic next_is_sync;
  logic next_clears_good;
  logic next_counts_good;

  // Both comma polarities share the 7-bit comma pattern in bits a..g.
  assign comma       = (code_group_in[9:3] == 7'b0011111) |
                       (code_group_in[9:3] == 7'b1100000);
  assign valid_comma = comma & cg_exists;
  assign data        = cg_exists & ~comma;
  // A comma is only legal in an even slot, i.e. after an odd group.
  assign cgbad       = ~cg_exists | (comma & rx_even);
  assign cggood      = ~cgbad;
  assign good_max    = (good_cgs == 3'(GOOD_CGS_MAX));

  always_comb begin
    next_state = LOSS_OF_SYNC;
    case (state)
      LOSS_OF_SYNC:
        next_state = valid_comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
      COMMA_DETECT_1:
        if (data) next_state = (COMMAS_TO_SYNC == 1) ? SYNC_ACQUIRED_1 : ACQUIRE_SYNC_1;
      ACQUIRE_SYNC_1:
        if (cgbad)                  next_state = LOSS_OF_SYNC;
        else if (comma && !rx_even) next_state = COMMA_DETECT_2;
        else                        next_state = ACQUIRE_SYNC_1;
      COMMA_DETECT_2:
        if (data) next_state = (COMMAS_TO_SYNC == 2) ? SYNC_ACQUIRED_1 : ACQUIRE_SYNC_2;
      ACQUIRE_SYNC_2:
        if (cgbad)                  next_state = LOSS_OF_SYNC;
        else if (comma && !rx_even) next_state = COMMA_DETECT_3;
        else                        next_state = ACQUIRE_SYNC_2;
      COMMA_DETECT_3:
        if (data) next_state = SYNC_ACQUIRED_1;
      SYNC_ACQUIRED_1:
        next_state = cgbad ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
      SYNC_ACQUIRED_2:
        next_state = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_2A:
        if (cgbad)         next_state = SYNC_ACQUIRED_3;
        else if (good_max) next_state = SYNC_ACQUIRED_1;
        else               next_state = SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_3:
        next_state = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_3A:
        if (cgbad)         next_state = SYNC_ACQUIRED_4;
        else if (good_max) next_state = SYNC_ACQUIRED_2;
        else               next_state = SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_4:
        next_state = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
      SYNC_ACQUIRED_4A:
        if (cgbad)         next_state = LOSS_OF_SYNC;
        else if (good_max) next_state = SYNC_ACQUIRED_3;
        else               next_state = SYNC_ACQUIRED_4A;
      default:
        next_state = LOSS_OF_SYNC;
    endcase
  end

  // Classification of the next state drives the rx_even / good_cgs updates.
  always_comb begin
    next_is_cd       = 1'b0;
    next_is_sync     = 1'b0;
    next_clears_good = 1'b0;
    next_counts_good = 1'b0;
    case (next_state)
      COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3:
        next_is_cd = 1'b1;
      SYNC_ACQUIRED_1:
        next_is_sync = 1'b1;
      SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
        next_is_sync     = 1'b1;
        next_clears_good = 1'b1;
      end
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
        next_is_sync     = 1'b1;
        next_counts_good = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= LOSS_OF_SYNC;
      sync_status          <= 1'b0;
      rx_even              <= 1'b0;
      good_cgs             <= 3'd0;
      code_group_out       <= 10'd0;
      code_group_out_valid <= 1'b0;
    end else begin
      // Forwarding is independent of signal_detect: a strobe is always passed on.
      code_group_out_valid <= cg_strobe;
      if (cg_strobe) code_group_out <= code_group_in;

      if (!signal_detect) begin
        state       <= LOSS_OF_SYNC;
        sync_status <= 1'b0;
        good_cgs    <= 3'd0;
      end else if (cg_strobe) begin
        state       <= next_state;
        sync_status <= next_is_sync;
        rx_even     <= next_is_cd ? 1'b1 : ~rx_even;
        if (next_clears_good)
          good_cgs <= 3'd0;
        else if (next_counts_good)
          good_cgs <= (good_cgs == 3'd7) ? 3'd7 : good_cgs + 3'd1;
      end
    end
  end

  assign sync_state = state;

endmodule
`default_nettype wire

// File: tb/tb_pcs_sync_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pcs_sync_fsm
// Purpose  : Self-checking bench for pcs_sync_fsm. Directed sequences cover
//            reset, acquisition, recovery, loss and signal_detect handling;
//            a randomized phase follows. A behavioural model tracks sync as
//            "commas accepted / awaiting data / sync level / recovering" and
//            pushes expected results into a scoreboard popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_sync_fsm;

  localparam int C_COMMAS = 3;
  localparam int C_GOOD   = 3;
  localparam logic [9:0] K28 = 10'b0011111010;
  localparam logic [9:0] DCG = 10'b1001110100;

  logic       clk = 1'b0;
  logic       reset, signal_detect, cg_strobe, cg_exists;
  logic [9:0] code_group_in;
  logic       sync_status, rx_even, code_group_out_valid;
  logic [9:0] code_group_out;
  logic [3:0] sync_state;

  always #5 clk = ~clk;

  pcs_sync_fsm #(.COMMAS_TO_SYNC(C_COMMAS), .GOOD_CGS_MAX(C_GOOD)) dut (
    .clk                  (clk),
    .reset                (reset),
    .signal_detect        (signal_detect),
    .cg_strobe            (cg_strobe),
    .code_group_in        (code_group_in),
    .cg_exists            (cg_exists),
    .sync_status          (sync_status),
    .rx_even              (rx_even),
    .code_group_out       (code_group_out),
    .code_group_out_valid (code_group_out_valid),
    .sync_state           (sync_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] cg;
    logic [3:0] st;
    logic       stat;
    logic       ev;
    int         due;
  } exp_t;
  exp_t q[$];

  // ---------------- behavioural model ----------------
  bit m_sync = 0;      // in one of the sync-acquired levels
  int m_commas = 0;    // aligned commas accepted during acquisition
  bit m_wait = 0;      // a comma was just accepted, a data group must follow
  int m_level = 1;     // sync level 1..4 (number of unrecovered errors + 1)
  bit m_rec = 0;       // counting good groups towards stepping down a level
  int m_gc = 0;
  bit m_even = 0;

  function automatic int model_code();
    if (!m_sync) begin
      if (m_commas == 0) return 0;
      return m_wait ? 2 * m_commas - 1 : 2 * m_commas;
    end
    if (m_level == 1) return 6;
    return 7 + 2 * (m_level - 2) + (m_rec ? 1 : 0);
  endfunction

  function automatic bit is_comma(input logic [9:0] cg);
    return (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
  endfunction

  task automatic model_loss();
    m_sync = 0; m_commas = 0; m_wait = 0;
  endtask

  task automatic model_strobe(input logic [9:0] cg, input logic ex);
    bit cm, bad, dat;
    cm  = is_comma(cg);
    bad = !ex || (cm && m_even);
    dat = ex && !cm;
    if (!m_sync) begin
      if (m_commas == 0) begin
        if (cm && ex) begin m_commas = 1; m_wait = 1; m_even = 1; end
        else m_even = !m_even;
      end else if (m_wait) begin
        m_even = !m_even;
        if (dat) begin
          m_wait = 0;
          if (m_commas == C_COMMAS) begin m_sync = 1; m_level = 1; m_rec = 0; end
        end else model_loss();
      end else begin
        if (bad) begin model_loss(); m_even = !m_even; end
        else if (cm && !m_even) begin m_commas++; m_wait = 1; m_even = 1; end
        else m_even = !m_even;
      end
    end else begin
      m_even = !m_even;
      if (bad) begin
        if (m_level == 4) model_loss();
        else begin m_level++; m_rec = 0; m_gc = 0; end
      end else if (m_level > 1) begin
        if (!m_rec) begin m_rec = 1; m_gc = (m_gc < 7) ? m_gc + 1 : 7; end
        else if (m_gc == C_GOOD) begin
          m_level--; m_rec = 0;
          if (m_level > 1) m_gc = 0;
        end else m_gc = (m_gc < 7) ? m_gc + 1 : 7;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every forwarded group is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_valid", 32'(code_group_out_valid), 32'd1);
      void'(q.pop_front());
    end
    if (code_group_out_valid === 1'b1) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        chk("unexpected_valid", 32'(code_group_out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_cg_out", 32'(code_group_out), 32'(e.cg));
        chk("sb_state",  32'(sync_state),     32'(e.st));
        chk("sb_status", 32'(sync_status),    32'(e.stat));
        chk("sb_rx_even", 32'(rx_even),       32'(e.ev));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the edge that consumed it.
  task automatic step(input logic rst_i, input logic sd_i, input logic stb_i,
                      input logic [9:0] cg_i, input logic ex_i);
    exp_t e;
    reset = rst_i; signal_detect = sd_i; cg_strobe = stb_i;
    code_group_in = cg_i; cg_exists = ex_i;
    if (rst_i) begin
      model_loss(); m_even = 0; m_gc = 0;
    end else begin
      if (!sd_i) begin model_loss(); m_gc = 0; end
      else if (stb_i) model_strobe(cg_i, ex_i);
      if (stb_i) begin
        e.cg = cg_i; e.st = 4'(model_code()); e.stat = m_sync;
        e.ev = m_even; e.due = cyc + 1;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_st(input string nm, input int st, input logic stat);
    chk({nm, "_state"},  32'(sync_state),  32'(st));
    chk({nm, "_status"}, 32'(sync_status), 32'(stat));
  endtask

  task automatic acquire();
    for (int i = 0; i < C_COMMAS; i++) begin
      step(0, 1, 1, K28, 1);
      step(0, 1, 1, DCG, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] cg;
    int r;
    reset = 1; signal_detect = 1; cg_strobe = 0; code_group_in = '0; cg_exists = 0;
    @(posedge clk); #1;

    // Reset with strobes active
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, K28, 1);
      chk("rst_state",  32'(sync_state), 32'd0);
      chk("rst_status", 32'(sync_status), 32'd0);
      chk("rst_even",   32'(rx_even), 32'd0);
      chk("rst_cgout",  32'(code_group_out), 32'd0);
      chk("rst_valid",  32'(code_group_out_valid), 32'd0);
    end

    // Acquisition: 1,2,3,4,5,6
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, K28, 1);
      expect_st("acq_comma", 2 * i + 1, 1'b0);
      chk("acq_comma_even", 32'(rx_even), 32'd1);
      step(0, 1, 1, DCG, 1);
      expect_st("acq_data", 2 * i + 2, (i == 2) ? 1'b1 : 1'b0);
    end

    // One bad group then recovery: 7,8,8,8,6
    step(0, 1, 1, DCG, 0); expect_st("rec_bad", 7, 1'b1);
    step(0, 1, 1, DCG, 1); expect_st("rec_g1", 8, 1'b1);
    step(0, 1, 1, DCG, 1); expect_st("rec_g2", 8, 1'b1);
    step(0, 1, 1, DCG, 1); expect_st("rec_g3", 8, 1'b1);
    step(0, 1, 1, DCG, 1); expect_st("rec_g4", 6, 1'b1);

    // Four bad groups: 7,9,11,0
    step(0, 1, 1, DCG, 0); expect_st("loss_b1", 7, 1'b1);
    step(0, 1, 1, DCG, 0); expect_st("loss_b2", 9, 1'b1);
    step(0, 1, 1, DCG, 0); expect_st("loss_b3", 11, 1'b1);
    step(0, 1, 1, DCG, 0); expect_st("loss_b4", 0, 1'b0);

    // Misaligned comma in ACQUIRE_SYNC_1
    step(0, 1, 1, K28, 1); expect_st("mis_k", 1, 1'b0);
    step(0, 1, 1, DCG, 1); expect_st("mis_d1", 2, 1'b0);
    step(0, 1, 1, DCG, 1); expect_st("mis_d2", 2, 1'b0);
    step(0, 1, 1, K28, 1); expect_st("mis_comma", 0, 1'b0);

    // Misaligned comma in SYNC_ACQUIRED_1
    acquire();             expect_st("resync", 6, 1'b1);
    step(0, 1, 1, DCG, 1); expect_st("sa1_data", 6, 1'b1);
    step(0, 1, 1, K28, 1); expect_st("sa1_comma", 7, 1'b1);

    // signal_detect drop without strobe, then gapped acquisition
    step(0, 0, 0, DCG, 1); expect_st("sd_drop", 0, 1'b0);
    step(0, 1, 1, K28, 1); expect_st("gap_k", 1, 1'b0);
    step(0, 1, 0, DCG, 1); expect_st("gap_i1", 1, 1'b0);
    chk("gap_valid", 32'(code_group_out_valid), 32'd0);
    step(0, 1, 0, K28, 0); expect_st("gap_i2", 1, 1'b0);
    step(0, 1, 1, DCG, 1); expect_st("gap_d", 2, 1'b0);
    step(0, 1, 0, K28, 1); expect_st("gap_i3", 2, 1'b0);
    step(0, 1, 1, K28, 1); step(0, 1, 1, DCG, 1);
    step(0, 1, 1, K28, 1); step(0, 1, 1, DCG, 1);
    expect_st("gap_sync", 6, 1'b1);

    // signal_detect drop with strobe: group still forwarded
    step(0, 0, 1, K28, 1); expect_st("sd_strobe", 0, 1'b0);
    chk("sd_fwd", 32'(code_group_out), 32'(K28));

    // Randomized phase; commas favoured in correctly aligned slots
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if ((m_even == 1'b0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 4)) begin
        cg = {($urandom_range(0, 1) == 1) ? 7'b0011111 : 7'b1100000, 3'($urandom)};
      end else begin
        cg = 10'($urandom);
        if (is_comma(cg)) cg[9] = ~cg[9];
      end
      step((r < 4) ? 1'b1 : 1'b0,
           (r >= 4 && r < 14) ? 1'b0 : 1'b1,
           ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           cg,
           ($urandom_range(0, 99) >= 7) ? 1'b1 : 1'b0);
    end

    // Drain
    for (int i = 0; i < 3; i++) step(0, 1, 0, DCG, 1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcs_sync_fsm.md
Name: pcs_sync_fsm

Overview:
- Receive-side code-group synchronization controller for the PCS receive path, modelled on the IEEE 802.3 Clause 36 synchronization state diagram.
- Consumes one 10-bit code group per strobe, together with the validity flag produced by the valid-code-group ROM lookup (`existence`).
- Detects commas internally, acquires and tracks even/odd code-group alignment, and declares sync_status OK or FAIL.
- Forwards aligned code groups to the receive decoder.

Parameters:
- COMMAS_TO_SYNC, 3: number of properly aligned comma+data pairs needed to reach sync; legal values 1..3.
- GOOD_CGS_MAX, 3: value good_cgs must hold, with another good code group arriving, to step back one loss level (4 consecutive good groups in total).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- signal_detect  in  1  PMA signal present; low forces loss of sync.
- cg_strobe  in  1  code_group_in / cg_exists are valid this cycle.
- code_group_in  in  10  received code group; bit 9 = 'a' (first bit), bit 0 = 'j'.
- cg_exists  in  1  1 = code_group_in is a valid code group (driven by the ROM lookup existence output).
- sync_status  out  1  1 = OK (states SYNC_ACQUIRED_*), 0 = FAIL.
- rx_even  out  1  parity of the last consumed code group (1 = even).
- code_group_out  out  10  registered copy of the last consumed code group.
- code_group_out_valid  out  1  one-cycle pulse, 1 clk after each consumed strobe.
- sync_state  out  4  current state encoding (debug).

Behaviour:
- Reset values:
  - state = LOSS_OF_SYNC (0); sync_status = 0; rx_even = 0; good_cgs = 0; code_group_out = 0; code_group_out_valid = 0.
  - Reset mid-acquisition or mid-sync returns to these values on the next edge.
- signal_detect = 0 (reset low):
  - Next edge: state = LOSS_OF_SYNC, good_cgs = 0, rx_even holds.
  - Any strobe that cycle is still forwarded on code_group_out but not evaluated.
- cg_strobe = 0: state, rx_even and good_cgs hold; code_group_out_valid = 0 next cycle.
- Derived signals (combinational, current code_group_in):
  - comma = (code_group_in[9:3] == 7'b0011111) | (code_group_in[9:3] == 7'b1100000).
  - valid_comma = comma & cg_exists.
  - data = cg_exists & ~comma.
  - cgbad = ~cg_exists | (comma & rx_even).
  - cggood = ~cgbad.
- Comma alignment rule: a comma is legal only when the previous code group was odd (rx_even = 0).
- State encoding: LOSS_OF_SYNC 0, COMMA_DETECT_1 1, ACQUIRE_SYNC_1 2, COMMA_DETECT_2 3, ACQUIRE_SYNC_2 4, COMMA_DETECT_3 5, SYNC_ACQUIRED_1 6, SYNC_ACQUIRED_2 7, SYNC_ACQUIRED_2A 8, SYNC_ACQUIRED_3 9, SYNC_ACQUIRED_3A 10, SYNC_ACQUIRED_4 11, SYNC_ACQUIRED_4A 12. Codes 13–15 → LOSS_OF_SYNC.
- rx_even update on each evaluated strobe: next-state COMMA_DETECT_x sets rx_even = 1; every other next-state sets rx_even = ~rx_even.
- good_cgs update: entering SYNC_ACQUIRED_2/3/4 clears it to 0; entering or staying in 2A/3A/4A increments it by 1 (3-bit, saturating at 7).
- Transitions, evaluated only on cg_strobe = 1:
  - LOSS_OF_SYNC: valid_comma → COMMA_DETECT_1; else stay.
  - COMMA_DETECT_k: data → ACQUIRE_SYNC_k (or SYNC_ACQUIRED_1 when k == COMMAS_TO_SYNC); else → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_k: cgbad → LOSS_OF_SYNC; else comma & ~rx_even → COMMA_DETECT_(k+1); else stay.
  - SYNC_ACQUIRED_1: cggood stay; cgbad → SYNC_ACQUIRED_2.
  - SYNC_ACQUIRED_n (n = 2, 3, 4): cggood → nA; cgbad → n+1 (4 → LOSS_OF_SYNC).
  - SYNC_ACQUIRED_nA: cgbad → n+1 (4A → LOSS_OF_SYNC); cggood & good_cgs == GOOD_CGS_MAX → n−1 (2A → SYNC_ACQUIRED_1); cggood otherwise → stay.
- Output latency and simultaneity:
  - sync_status is registered and reflects the new state 1 clk after the deciding strobe.
  - code_group_out and code_group_out_valid update on the same edge as the state.
  - Simultaneous reset, signal_detect = 0 and strobe: reset wins, then signal_detect.

Test Plan:
- Reset with strobes active → all outputs 0, sync_state = 0 held for 3 cycles.
- Alternate K28.5 (10'b0011111010, exists = 1) and D (10'b1001110100, exists = 1) for 3 pairs → sync_state 1,2,3,4,5,6; sync_status rises 1 clk after the 6th strobe; rx_even = 1 on each comma.
- In SYNC_ACQUIRED_1, inject 1 group with exists = 0 then 4 good data groups → states 7, 8, 8, 8, 6; sync_status stays 1.
- In sync, 4 consecutive exists = 0 groups → states 7, 9, 11, 0; sync_status = 0 after the 4th.
- Comma on an odd slot (comma while rx_even = 1) in ACQUIRE_SYNC_1 → LOSS_OF_SYNC; comma in SYNC_ACQUIRED_1 with rx_even = 1 → SYNC_ACQUIRED_2.
- In SYNC_ACQUIRED_1, drop signal_detect for 1 cycle → sync_state = 0, sync_status = 0 next edge; strobes gapped by cg_strobe = 0 do not advance the FSM.
